// File: rtl/uart_tx_frame_shifter.sv
// uart_tx_frame_shifter
//   UART transmit shifter. Each accepted word is sent as one frame:
//   start bit (0), DATA_W data bits LSB first, optional parity bit,
//   then STOP_BITS stop bits (1). Every bit is held for CLKS_PER_BIT cycles.
//
// Parameters:
//   DATA_W       data bits per frame (5..9)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//   CLKS_PER_BIT clk cycles per bit time (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; aborts any frame without done
//   data_in     word to send, sampled only when a load is accepted
//   load        request to send data_in (accepted while ready=1)
//   send_break  (UART_TX_BREAK_EN only) hold the line low for 2*FRAME_W
//               bit times; has priority over load in IDLE
//   ready       high when a load will be accepted
//   sdo         serial output, idle/mark = 1
//   busy        high while a frame (or break) is in progress
//   done        one-cycle pulse after the last stop bit (or break) ends
//
// Optional feature macro: UART_TX_BREAK_EN
module uart_tx_frame_shifter #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              ready,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FRAME_W = 1 + DATA_W + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
  localparam int unsigned PAR_POS = DATA_W + 1;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_BREAK_EN
  // The bit index also counts break bit times, which run to 2*FRAME_W.
  localparam int unsigned IDX_MAX = 2 * FRAME_W;
`else
  localparam int unsigned IDX_MAX = FRAME_W;
`endif
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_W - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [IDX_W-1:0] BREAK_LAST = IDX_W'(2 * FRAME_W - 1);
`endif

`ifdef UART_TX_BREAK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BREAK = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [FRAME_W-1:0] frame_reg;
  logic [FRAME_W-1:0] frame_load;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic               done_r;
  logic               par_bit;
  logic               bit_end;
  logic               frame_end;
  logic               break_req;
  logic               break_end;

  // ---------------------------------------------------------------------
  // Frame assembly: {stop 1s, [parity], data, start 0}, start bit at [0].
  // ---------------------------------------------------------------------
  always_comb begin
    par_bit = (PARITY_MODE == 2) ? ~(^data_in) : (^data_in);
  end

  always_comb begin
    frame_load                = '1;
    frame_load[0]             = 1'b0;
    frame_load[DATA_W:1]      = data_in;
    if (PARITY_MODE != 0) begin
      frame_load[PAR_POS]     = par_bit;
    end
  end

  // ---------------------------------------------------------------------
  // Bit timing decodes
  // ---------------------------------------------------------------------
  always_comb begin
    bit_end   = (bit_cnt == CNT_LAST);
    frame_end = bit_end && (bit_idx == FRAME_LAST);
`ifdef UART_TX_BREAK_EN
    break_req = send_break;
    break_end = bit_end && (bit_idx == BREAK_LAST);
`else
    break_req = 1'b0;
    break_end = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_nxt = BREAK;
        end else if (load) begin
          state_nxt = SHIFT;
        end
`else
        if (load) begin
          state_nxt = SHIFT;
        end
`endif
      end
      SHIFT: begin
        if (frame_end) begin
          state_nxt = IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (break_end) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: frame register, bit-time counter, bit index, done pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_reg <= '1;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (load && !break_req) begin
            frame_reg <= frame_load;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            bit_cnt   <= '0;
            bit_idx   <= bit_idx + IDX_W'(1);
            frame_reg <= {1'b1, frame_reg[FRAME_W-1:1]};
            done_r    <= frame_end;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + IDX_W'(1);
            done_r  <= break_end;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          bit_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    sdo   = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        sdo  = frame_reg[0];
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        busy = 1'b1;
        sdo  = 1'b0;
      end
`endif
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    done = done_r;
  end

endmodule

// File: tb/tb_uart_tx_frame_shifter.sv
// tb_uart_tx_frame_shifter
//   Drives three shifter instances (8N1, 8E1, 8O2, all 4 clk per bit) and
//   compares every cycle against a frame-timeline model: for each instance
//   the model only remembers when a frame was accepted and which word, and
//   derives sdo/ready/busy/done from the bit-time arithmetic.
module tb_uart_tx_frame_shifter;

  localparam int N   = 3;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       brk = 1'b0;
  logic [7:0] din [N];
  logic       ld  [N];
  logic       sdo [N];
  logic       rdy [N];
  logic       bsy [N];
  logic       dn  [N];

  always #5 clk = ~clk;

  uart_tx_frame_shifter #(
    .DATA_W(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)
  ) u0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .load(ld[0]),
`ifdef UART_TX_BREAK_EN
    .send_break(brk),
`endif
    .ready(rdy[0]), .sdo(sdo[0]), .busy(bsy[0]), .done(dn[0])
  );

  uart_tx_frame_shifter #(
    .DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)
  ) u1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .load(ld[1]),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .ready(rdy[1]), .sdo(sdo[1]), .busy(bsy[1]), .done(dn[1])
  );

  uart_tx_frame_shifter #(
    .DATA_W(8), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)
  ) u2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .load(ld[2]),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .ready(rdy[2]), .sdo(sdo[2]), .busy(bsy[2]), .done(dn[2])
  );

  // ---------------- model ----------------
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          act   [N];
  bit          bmode [N];
  int          kk    [N];
  logic [7:0]  mdat  [N];
  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  function automatic int pm(int i);
    return i;  // instance i uses parity mode i
  endfunction

  function automatic int sb(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int fw(int i);
    return 1 + 8 + ((pm(i) != 0) ? 1 : 0) + sb(i);
  endfunction

  function automatic int mlen(int i);
    return bmode[i] ? 2 * fw(i) * CPB : fw(i) * CPB;
  endfunction

  // Bit idx of the frame carrying mdat[i]: start, data LSB first, parity, stops.
  function automatic logic fbit(int i, int idx);
    logic p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return mdat[i][idx-1];
    if (idx == 9 && pm(i) != 0) begin
      p = (($countones(mdat[i]) % 2) == 1);
      return (pm(i) == 1) ? p : !p;
    end
    return 1'b1;
  endfunction

  function automatic bit m_busy(int i);
    return act[i] && ((cyc - kk[i]) < mlen(i));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
  endtask

  task automatic model_edge();
    int n = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        act[i] = 1'b0;
      end else if (!m_busy(i)) begin
        if (i == 0 && brk) begin
          act[i] = 1'b1; kk[i] = n; bmode[i] = 1'b1;
        end else if (ld[i]) begin
          act[i] = 1'b1; kk[i] = n; bmode[i] = 1'b0; mdat[i] = din[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      logic [3:0] exp_v;
      logic [3:0] got_v;
      int e;
      exp_v = 4'b1100;  // {sdo, ready, busy, done}
      if (act[i]) begin
        e = cyc - kk[i];
        if (e >= 0 && e < mlen(i))
          exp_v = {(bmode[i] ? 1'b0 : fbit(i, e / CPB)), 1'b0, 1'b1, 1'b0};
        else if (e == mlen(i))
          exp_v = 4'b1101;
      end
      got_v = {sdo[i], rdy[i], bsy[i], dn[i]};
      chk($sformatf("model_u%0d", i), 32'(got_v), 32'(exp_v));
    end
  endtask

  // Advance one edge: model samples the same inputs the DUTs sample, then
  // outputs are compared 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) ld[i] = 1'b0;
    brk = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          k;
    int          e;
    bit          ok;
    bit          seen;
    logic [9:0]  got0;
    logic [9:0]  seq41;

    for (int i = 0; i < N; i++) begin
      din[i] = '0; ld[i] = 1'b0; act[i] = 1'b0; bmode[i] = 1'b0; kk[i] = 0; mdat[i] = '0;
    end
    got0  = '0;
    seq41 = 10'b1010000010;  // idx9..idx0 of 0x41 in 8N1

    // Reset for 3 clocks, then idle for 100.
    rst = 1'b1;
    step(); chk_en = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_outputs_u0", 32'({sdo[0], rdy[0], bsy[0], dn[0]}), 32'h0000000C);
    ok = 1'b1;
    for (int t = 0; t < 100; t++) begin
      step();
      ok &= (sdo[0] === 1'b1) && (sdo[1] === 1'b1) && (sdo[2] === 1'b1);
    end
    chk("idle_sdo_100", 32'(ok), 32'd1);

    // 0x41 on 8N1, 0x07 on 8E1 and 8O2, all accepted on the same edge.
    din[0] = 8'h41; din[1] = 8'h07; din[2] = 8'h07;
    for (int i = 0; i < N; i++) ld[i] = 1'b1;
    step();
    k = cyc;
    clear_inputs();
    ok = 1'b1;
    for (int t = 0; t <= 48; t++) begin
      if (t > 0) step();
      e = cyc - k;
      if (e % CPB == 2 && e / CPB < 10) got0[e / CPB] = sdo[0];
      if (e < 40 && rdy[0] !== 1'b0) ok = 1'b0;
      if (e == 39) chk("u0_no_early_done", 32'(dn[0]), 32'd0);
      if (e == 40) chk("u0_done_cycle41", 32'({dn[0], rdy[0], sdo[0]}), 32'd7);
      if (e == 38) chk("u1_even_parity_07", 32'(sdo[1]), 32'd1);
      if (e == 38) chk("u2_odd_parity_07", 32'(sdo[2]), 32'd0);
      if (e == 42) chk("u2_stop1", 32'(sdo[2]), 32'd1);
      if (e == 46) chk("u2_stop2_busy", 32'({sdo[2], bsy[2]}), 32'd3);
      if (e == 48) chk("u2_done_48", 32'(dn[2]), 32'd1);
    end
    chk("u0_bits_0x41", 32'(got0), 32'(seq41));
    chk("u0_ready_low", 32'(ok), 32'd1);

    // Back-to-back 0x55 then 0xAA, with an ignored mid-frame load.
    repeat (5) step();
    din[0] = 8'h55; ld[0] = 1'b1;
    step();
    k = cyc;
    ld[0] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      step();
      e = cyc - k;
      ld[0] = (e == 20);
      if (e == 20) din[0] = 8'hFF;
      if (dn[0] === 1'b1) seen = 1'b1;
    end
    chk("b2b_done_seen", 32'(seen), 32'd1);
    din[0] = 8'hAA; ld[0] = 1'b1;
    step();
    ld[0] = 1'b0;
    chk("b2b_start_next", 32'({sdo[0], bsy[0]}), 32'd1);
    repeat (45) step();

    // Reset at cycle 15 of a frame.
    din[0] = 8'h41; ld[0] = 1'b1;
    step();
    k = cyc;
    ld[0] = 1'b0;
    while (cyc - k < 14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_abort_idle", 32'({sdo[0], rdy[0], bsy[0], dn[0]}), 32'h0000000C);
    ok = 1'b1;
    for (int t = 0; t < 50; t++) begin
      step();
      if (dn[0] !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_done", 32'(ok), 32'd1);
    din[0] = 8'h41; ld[0] = 1'b1;
    step();
    ld[0] = 1'b0;
    repeat (45) step();

`ifdef UART_TX_BREAK_EN
    // Break has priority over a simultaneous load.
    brk = 1'b1; din[0] = 8'h41; ld[0] = 1'b1;
    step();
    k = cyc;
    clear_inputs();
    for (int t = 0; t <= 81; t++) begin
      if (t > 0) step();
      e = cyc - k;
      if (e == 0)  chk("brk_start", 32'({sdo[0], rdy[0], bsy[0]}), 32'd1);
      if (e == 40) chk("brk_low_at_40", 32'(sdo[0]), 32'd0);
      if (e == 79) chk("brk_low_at_79", 32'({sdo[0], dn[0]}), 32'd0);
      if (e == 80) chk("brk_done_81", 32'({dn[0], rdy[0], sdo[0]}), 32'd7);
      if (e == 81) chk("brk_load_not_taken", 32'(bsy[0]), 32'd0);
    end
`endif

    // Randomised traffic, occasional reset (and break when built in).
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        ld[i]  = ($urandom_range(0, 7) == 0);
        din[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
`ifdef UART_TX_BREAK_EN
      brk = ($urandom_range(0, 199) == 0);
`endif
      step();
    end
    clear_inputs();
    rst = 1'b0;
    repeat (120) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
